// File: rtl/axi4lite_arb_pkg.sv
// Shared types and constants for the AXI4-Lite master arbiter.
package axi4lite_arb_pkg;

  // Transaction sequencer states: one command is carried end to end at a time.
  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } t_arb_state;

  // AXI BRESP/RRESP encodings.
  localparam logic [1:0] C_RESP_OKAY   = 2'b00;
  localparam logic [1:0] C_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;
  localparam logic [1:0] C_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi4lite_master_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts just after last_grant
// and wraps, so the most recently served requester has the lowest priority.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last_grant,
  output logic [N-1:0]         grant
);

  logic found;

  // Two ordered passes: indices above last_grant first, then the wrapped part.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i > int'(last_grant))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i <= int'(last_grant))) begin
        grant[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi4lite_master_arbiter.sv
// Shares one AXI4-Lite master port among G_NB_REQ single-beat requesters.
// One transaction is in flight at a time; each is fully sequenced through
// AW/W/B or AR/R before the next round-robin grant.
module axi4lite_master_arbiter
  import axi4lite_arb_pkg::*;
#(
  parameter int          G_NB_REQ               = 4,
  parameter int          G_AXI4_LITE_ADDR_WIDTH = 32,
  parameter int          G_AXI4_LITE_DATA_WIDTH = 32,
  parameter logic [2:0]  G_AWPROT               = 3'b000,
  parameter logic [2:0]  G_ARPROT               = 3'b000
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  // Requester side
  input  logic [G_NB_REQ-1:0]                        req_valid,
  output logic [G_NB_REQ-1:0]                        req_ready,
  input  logic [G_NB_REQ-1:0]                        req_wr,
  input  logic [G_NB_REQ*G_AXI4_LITE_ADDR_WIDTH-1:0] req_addr,
  input  logic [G_NB_REQ*G_AXI4_LITE_DATA_WIDTH-1:0] req_wdata,
  input  logic [G_NB_REQ*G_AXI4_LITE_DATA_WIDTH/8-1:0] req_wstrb,
  output logic [G_NB_REQ-1:0]                        rsp_valid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                                 rsp_resp,
  // AXI4-Lite master port
  output logic                                       awvalid,
  output logic [G_AXI4_LITE_ADDR_WIDTH-1:0]          awaddr,
  output logic [2:0]                                 awprot,
  input  logic                                       awready,
  output logic                                       wvalid,
  output logic [G_AXI4_LITE_DATA_WIDTH-1:0]          wdata,
  output logic [G_AXI4_LITE_DATA_WIDTH/8-1:0]        wstrb,
  input  logic                                       wready,
  input  logic                                       bvalid,
  input  logic [1:0]                                 bresp,
  output logic                                       bready,
  output logic                                       arvalid,
  output logic [G_AXI4_LITE_ADDR_WIDTH-1:0]          araddr,
  output logic [2:0]                                 arprot,
  input  logic                                       arready,
  input  logic                                       rvalid,
  input  logic [G_AXI4_LITE_DATA_WIDTH-1:0]          rdata,
  input  logic [1:0]                                 rresp,
  output logic                                       rready
);

  localparam int N  = G_NB_REQ;
  localparam int A  = G_AXI4_LITE_ADDR_WIDTH;
  localparam int D  = G_AXI4_LITE_DATA_WIDTH;
  localparam int S  = D / 8;
  localparam int IW = $clog2(N);

  t_arb_state        state_q;
  logic [IW-1:0]     last_grant_q;
  logic [N-1:0]      grant_q;
  logic [A-1:0]      addr_q;
  logic [D-1:0]      wdata_q;
  logic [S-1:0]      wstrb_q;
  logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [N-1:0]      rsp_valid_q;
  logic [D-1:0]      rsp_rdata_q;
  logic [1:0]        rsp_resp_q;

  logic [N-1:0]      grant;
  logic [IW-1:0]     sel_idx;
  logic              sel_wr;
  logic [A-1:0]      sel_addr;
  logic [D-1:0]      sel_wdata;
  logic [S-1:0]      sel_wstrb;
  logic              aw_done, w_done;

  rr_arbiter #(.N(N)) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Mux the winning requester's command fields out of the flattened buses.
  always_comb begin
    sel_idx   = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_idx   = IW'(i);
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[i*A +: A];
        sel_wdata = req_wdata[i*D +: D];
        sel_wstrb = req_wstrb[i*S +: S];
      end
    end
  end

  // A channel is finished once its valid has dropped or is handshaking now.
  assign aw_done = !awvalid_q || awready;
  assign w_done  = !wvalid_q  || wready;

  // Transaction sequencer with registered bus and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(N - 1);
      grant_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_resp_q   <= C_RESP_OKAY;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      case (state_q)
        IDLE: begin
          if (|grant) begin
            grant_q      <= grant;
            last_grant_q <= sel_idx;
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            wstrb_q      <= sel_wstrb;
            if (sel_wr) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_REQ;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready_q    <= 1'b0;
            rsp_resp_q  <= bresp;
            rsp_rdata_q <= '0;
            rsp_valid_q <= grant_q;
            state_q     <= RSP;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready_q    <= 1'b0;
            rsp_resp_q  <= rresp;
            rsp_rdata_q <= rdata;
            rsp_valid_q <= grant_q;
            state_q     <= RSP;
          end
        end
        RSP: begin
          rsp_valid_q <= '0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accept is only offered while idle and out of reset.
  assign req_ready = (rst_n && state_q == IDLE) ? grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

  assign awvalid = awvalid_q;
  assign awaddr  = addr_q;
  assign awprot  = G_AWPROT;
  assign wvalid  = wvalid_q;
  assign wdata   = wdata_q;
  assign wstrb   = wstrb_q;
  assign bready  = bready_q;
  assign arvalid = arvalid_q;
  assign araddr  = addr_q;
  assign arprot  = G_ARPROT;
  assign rready  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_arbiter.sv
// Directed bench for axi4lite_master_arbiter: a configurable AXI4-Lite slave,
// a response scoreboard and a linear sequence of directed scenarios.
module tb_axi4lite_master_arbiter;
  import axi4lite_arb_pkg::*;

  localparam int N = 4;
  localparam int A = 32;
  localparam int D = 32;
  localparam int S = D / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, req_wr, rsp_valid;
  logic [N*A-1:0] req_addr;
  logic [N*D-1:0] req_wdata;
  logic [N*S-1:0] req_wstrb;
  logic [D-1:0]   rsp_rdata;
  logic [1:0]     rsp_resp;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready;
  logic [A-1:0]   awaddr, araddr;
  logic [2:0]     awprot, arprot;
  logic [D-1:0]   wdata, rdata;
  logic [S-1:0]   wstrb;
  logic [1:0]     bresp, rresp;

  axi4lite_master_arbiter #(
    .G_NB_REQ(N), .G_AXI4_LITE_ADDR_WIDTH(A), .G_AXI4_LITE_DATA_WIDTH(D),
    .G_AWPROT(3'b000), .G_ARPROT(3'b000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awaddr(awaddr), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arprot(arprot), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready)
  );

  typedef struct {
    int         idx;
    logic [D-1:0] rdata;
    logic [1:0] resp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_rsp = 0;

  // Slave behaviour knobs: ready/valid delays in cycles and returned values.
  int         aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0;
  logic [D-1:0] rdata_cfg = '0;
  logic [1:0] rresp_cfg = C_RESP_OKAY;
  logic [1:0] bresp_cfg = C_RESP_OKAY;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int idx, input logic [D-1:0] rd, input logic [1:0] resp);
    exp_t e;
    e.idx = idx;
    e.rdata = rd;
    e.resp = resp;
    exp_q.push_back(e);
  endtask

  task automatic drive(input int i, input logic wr, input logic [A-1:0] addr,
                       input logic [D-1:0] data, input logic [S-1:0] strb);
    req_valid[i] = 1'b1;
    req_wr[i] = wr;
    req_addr[i*A +: A] = addr;
    req_wdata[i*D +: D] = data;
    req_wstrb[i*S +: S] = strb;
  endtask

  task automatic wait_rsp_count(input int target, input string tag);
    int c = 0;
    while (n_rsp < target && c < 200) begin
      @(negedge clk);
      c++;
    end
    check(tag, 64'(n_rsp), 64'(target));
  endtask

  // AXI4-Lite slave: readies/valids decided at the falling edge.
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0;
  initial begin
    awready = 1'b0; wready = 1'b0; arready = 1'b0;
    bvalid = 1'b0; bresp = '0; rvalid = 1'b0; rdata = '0; rresp = '0;
    forever begin
      @(negedge clk);
      if (awvalid) begin awready = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin awready = 1'b0; aw_cnt = 0; end
      if (wvalid) begin wready = (w_cnt >= w_wait); w_cnt++; end
      else begin wready = 1'b0; w_cnt = 0; end
      if (arvalid) begin arready = (ar_cnt >= ar_wait); ar_cnt++; end
      else begin arready = 1'b0; ar_cnt = 0; end
      if (bready) begin bvalid = (b_cnt >= b_wait); b_cnt++; end
      else begin bvalid = 1'b0; b_cnt = 0; end
      bresp = bresp_cfg;
      rvalid = rready;
      rdata = rdata_cfg;
      rresp = rresp_cfg;
    end
  end

  // Response monitor: pop the scoreboard on every rsp_valid pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid != '0) begin
        logic [N-1:0] oh;
        exp_t e;
        n_rsp++;
        check("rsp_was_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          oh = N'(1) << e.idx;
          check("rsp_valid_onehot", 64'(rsp_valid), 64'(oh));
          check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
        end
        check("rsp_nothing_in_flight", 64'({awvalid, wvalid, arvalid, bready, rready}), 64'(0));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ar_cycles;
    int acc;
    int base;

    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;

    // ---- Reset state (a request held during reset must not be accepted)
    repeat (2) @(negedge clk);
    req_valid[2] = 1'b1;
    #1;
    check("rst_ctrl", 64'({req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    check("rst_addr", 64'({awaddr, araddr}), 64'(0));
    check("rst_wdata", 64'({wdata, wstrb}), 64'(0));
    check("rst_rsp", 64'({rsp_rdata, rsp_resp}), 64'(0));
    check("prot_const", 64'({awprot, arprot}), 64'(0));
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;

    // ---- T1: requester 0 write, zero-wait slave, latency profile
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    push_exp(0, '0, C_RESP_OKAY);
    @(negedge clk);
    check("t1_req_ready", 64'(req_ready), 64'(4'b0001));
    @(posedge clk); #1 req_valid = '0;            // accept edge T
    @(negedge clk);                               // T+1
    check("t1_aw_w_valid", 64'({awvalid, wvalid, arvalid, bready}), 64'(4'b1100));
    check("t1_awaddr", 64'(awaddr), 64'(32'h10));
    check("t1_wdata", 64'(wdata), 64'(32'hDEADBEEF));
    check("t1_wstrb", 64'(wstrb), 64'(4'hF));
    @(negedge clk);                               // T+2
    check("t1_bready", 64'({awvalid, wvalid, bready}), 64'(3'b001));
    @(negedge clk);                               // T+3
    check("t1_rsp_latency", 64'(rsp_valid), 64'(4'b0001));
    @(negedge clk);                               // T+4
    check("t1_rsp_one_cycle", 64'(rsp_valid), 64'(0));
    wait_rsp_count(1, "t1_rsp_count");

    // ---- T2: requester 2 read, arready held low 3 cycles
    ar_wait = 3; rdata_cfg = 32'h12345678; rresp_cfg = C_RESP_SLVERR;
    @(posedge clk); #1;
    drive(2, 1'b0, 32'h20, '0, '0);
    push_exp(2, 32'h12345678, C_RESP_SLVERR);
    @(negedge clk);
    check("t2_req_ready", 64'(req_ready), 64'(4'b0100));
    @(posedge clk); #1 req_valid = '0;
    ar_cycles = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (arvalid) begin
        ar_cycles++;
        if (ar_cycles == 1) check("t2_araddr", 64'(araddr), 64'(32'h20));
      end else if (ar_cycles > 0) begin
        break;
      end
    end
    check("t2_arvalid_cycles", 64'(ar_cycles), 64'(4));
    wait_rsp_count(2, "t2_rsp_count");
    ar_wait = 0;

    // ---- T4: requester 3 write, wready two cycles before awready
    aw_wait = 2; w_wait = 0; bresp_cfg = C_RESP_EXOKAY;
    @(posedge clk); #1;
    drive(3, 1'b1, 32'h30, 32'h0BADF00D, 4'h3);
    push_exp(3, '0, C_RESP_EXOKAY);
    @(negedge clk);
    check("t4_req_ready", 64'(req_ready), 64'(4'b1000));
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("t4_c1", 64'({awvalid, wvalid, bready}), 64'(3'b110));
    @(negedge clk);
    check("t4_c2_w_dropped", 64'({awvalid, wvalid, bready}), 64'(3'b100));
    @(negedge clk);
    check("t4_c3_aw_held", 64'({awvalid, wvalid, bready}), 64'(3'b100));
    @(negedge clk);
    check("t4_c4_bready", 64'({awvalid, wvalid, bready}), 64'(3'b001));
    wait_rsp_count(3, "t4_rsp_count");
    aw_wait = 0; bresp_cfg = C_RESP_OKAY;

    // ---- T5: reset asserted while waiting in WR_RESP
    b_wait = 100;
    base = n_rsp;
    @(posedge clk); #1;
    drive(1, 1'b1, 32'h40, 32'h11112222, 4'hF);
    @(posedge clk); #1 req_valid = '0;
    for (int c = 0; c < 10 && !bready; c++) @(negedge clk);
    check("t5_reach_wr_resp", 64'(bready), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", 64'({req_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 64'(0));
    check("t5_rst_addr", 64'({awaddr, araddr}), 64'(0));
    check("t5_rst_wdata", 64'({wdata, wstrb}), 64'(0));
    b_wait = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("t5_no_rsp", 64'(n_rsp), 64'(base));

    // ---- T3: all four held valid, order 0,1,2,3,0 after reset
    rdata_cfg = 32'hCAFEF00D; rresp_cfg = C_RESP_OKAY; bresp_cfg = C_RESP_OKAY;
    base = n_rsp;
    push_exp(0, '0, C_RESP_OKAY);
    push_exp(1, 32'hCAFEF00D, C_RESP_OKAY);
    push_exp(2, '0, C_RESP_OKAY);
    push_exp(3, 32'hCAFEF00D, C_RESP_OKAY);
    push_exp(0, '0, C_RESP_OKAY);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h100, 32'hA0A0A0A0, 4'hF);
    drive(1, 1'b0, 32'h104, '0, '0);
    drive(2, 1'b1, 32'h108, 32'hB1B1B1B1, 4'hC);
    drive(3, 1'b0, 32'h10C, '0, '0);
    acc = 0;
    for (int c = 0; c < 100 && acc < 5; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        acc++;
        check("t3_ready_onehot", 64'($onehot(req_ready)), 64'(1));
        if (acc == 5) begin
          @(posedge clk); #1 req_valid = '0;
        end
      end
    end
    check("t3_accepts", 64'(acc), 64'(5));
    wait_rsp_count(base + 5, "t3_rsp_count");

    // ---- T6: requester 1 idle, 0 and 3 contend; order 3,0,3,0
    rdata_cfg = 32'h5555AAAA; rresp_cfg = C_RESP_DECERR; bresp_cfg = C_RESP_SLVERR;
    base = n_rsp;
    push_exp(3, 32'h5555AAAA, C_RESP_DECERR);
    push_exp(0, '0, C_RESP_SLVERR);
    push_exp(3, 32'h5555AAAA, C_RESP_DECERR);
    push_exp(0, '0, C_RESP_SLVERR);
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h200, 32'h01234567, 4'hF);
    drive(3, 1'b0, 32'h20C, '0, '0);
    acc = 0;
    for (int c = 0; c < 100 && acc < 4; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        acc++;
        if (acc == 4) begin
          @(posedge clk); #1 req_valid = '0;
        end
      end
    end
    check("t6_accepts", 64'(acc), 64'(4));
    wait_rsp_count(base + 4, "t6_rsp_count");

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
